// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset main controller:
// FSM states, datapath select codes, opcode classes and ALU command values.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CMD_W   = 4;

  // Controller states; any encoding outside this list recovers to S_FETCH
  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_UNKNOWN = 4'd10
  } state_t;

  // ALUControl
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Op field classes
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UNK = 2'b11;

  // Data-processing commands, Funct[4:1]
  localparam logic [CMD_W-1:0] CMD_ADD = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AND = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_ORR = 4'b1100;
  localparam logic [CMD_W-1:0] CMD_CMP = 4'b1010;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU decoder: maps Funct to ALU operation and flag-write
// enables while decode is active; no_write marks CMP and unsupported commands
// so the following writeback suppresses its register write.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  input  logic       alu_op,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w,
  output logic       no_write
);

  logic [CMD_W-1:0] cmd;
  logic [1:0]       ctl;
  logic             supported;
  logic             unused_funct5;

  assign cmd           = funct[4:1];
  assign unused_funct5 = funct[5];

  // Command lookup; no_write stays valid outside the execute states
  always_comb begin
    ctl       = ALU_ADD;
    supported = 1'b1;
    no_write  = 1'b0;
    case (cmd)
      CMD_ADD: ctl = ALU_ADD;
      CMD_SUB: ctl = ALU_SUB;
      CMD_AND: ctl = ALU_AND;
      CMD_ORR: ctl = ALU_ORR;
      CMD_CMP: begin
        ctl      = ALU_SUB;
        no_write = 1'b1;
      end
      default: begin
        supported = 1'b0;
        no_write  = 1'b1;
      end
    endcase
  end

  // Outputs only take the decoded values while decode is active
  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    if (alu_op) begin
      alu_control = ctl;
      flag_w[1]   = funct[0] & supported;
      flag_w[0]   = funct[0] & supported & ((ctl == ALU_ADD) | (ctl == ALU_SUB));
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle main controller and instruction decoder for the ARM-subset core.
// Walks each instruction through fetch/decode/execute/memory/writeback and
// produces the raw write requests plus all datapath selects.
// Optional feature: define MC_BL_LINK_EN to make BL write the link register
// from the BRANCH state (LinkW); otherwise LinkW is tied 0.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  output logic [3:0]  Cond,
  output logic        PCS,
  output logic        RegW,
  output logic        MemW,
  output logic [1:0]  FlagW,
  output logic        NextPC,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        LinkW
);

  state_t     state_q;
  state_t     state_d;

  logic [1:0] op;
  logic [5:0] funct;
  logic       rd_is_pc;
  logic       unused_instr;

  logic       irwrite_s;
  logic       nextpc_s;
  logic       regw_s;
  logic       memw_s;
  logic       branch_s;
  logic       alu_op_s;
  logic [1:0] flagw_s;
  logic       no_write;
`ifdef MC_BL_LINK_EN
  logic       link_s;
`endif

  assign op           = Instr[27:26];
  assign funct        = Instr[25:20];
  assign rd_is_pc     = (Instr[15:12] == 4'hF);
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  // Instruction-field pass-throughs
  assign Cond   = Instr[31:28];
  assign ImmSrc = op;
  assign RegSrc = {op == OP_MEM, op == OP_BR};

  mc_alu_dec u_alu_dec (
    .funct       (funct),
    .alu_op      (alu_op_s),
    .alu_control (ALUControl),
    .flag_w      (flagw_s),
    .no_write    (no_write)
  );

  // State register; reset forces FETCH asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and per-state Moore outputs
  always_comb begin
    state_d   = S_FETCH;
    irwrite_s = 1'b0;
    nextpc_s  = 1'b0;
    regw_s    = 1'b0;
    memw_s    = 1'b0;
    branch_s  = 1'b0;
    alu_op_s  = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
`ifdef MC_BL_LINK_EN
    link_s    = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        state_d   = S_DECODE;
        irwrite_s = 1'b1;
        nextpc_s  = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        case (op)
          OP_MEM: state_d = S_MEMADR;
          OP_DP:  state_d = funct[5] ? S_EXECI : S_EXECR;
          OP_BR:  state_d = S_BRANCH;
          OP_UNK: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_d = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        regw_s    = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        memw_s = 1'b1;
      end
      S_EXECR: begin
        alu_op_s = 1'b1;
        ALUSrcB  = SRCB_REG;
        state_d  = S_ALUWB;
      end
      S_EXECI: begin
        alu_op_s = 1'b1;
        ALUSrcB  = SRCB_IMM;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        regw_s    = ~no_write;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        branch_s  = 1'b1;
`ifdef MC_BL_LINK_EN
        if (funct[4]) begin
          regw_s = 1'b1;
          link_s = 1'b1;
        end
`endif
      end
      S_UNKNOWN: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Write requests are squashed the instant reset asserts; the Rd==15 term
  // is not applied in BRANCH so a link write never looks like a PC write
  assign PCS     = reset & (branch_s | (regw_s & rd_is_pc & ~branch_s));
  assign RegW    = reset & regw_s;
  assign MemW    = reset & memw_s;
  assign FlagW   = reset ? flagw_s : 2'b00;
  assign NextPC  = reset & nextpc_s;
  assign IRWrite = reset & irwrite_s;
`ifdef MC_BL_LINK_EN
  assign LinkW   = reset & link_s;
`else
  assign LinkW   = 1'b0;
`endif

endmodule
